divider_rr_arbiter: RTL and testbench

- Shares one unsigned_nonrestoring divider instance among NUM_REQ requesters using round-robin arbitration.
- Accepts one operand pair per requester via valid/ready and sequences the divider's go/done protocol.
- Captures the divider's one-cycle done pulse and holds the result until the winning requester accepts it.
- Sits between client blocks and the shared divider in the arithmetic subsystem.

---
 rtl/divider_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_divider_rr_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_rr_arbiter.sv
// divider_rr_arbiter: round-robin front end that shares one divider among
// NUM_REQ requesters. It takes one operand pair per transaction, runs the
// divider's go/done sequence, and holds the result until the winner takes it.
//
// Optional feature macro: DIV_ARB_ZERO_BYPASS_EN. When it is defined, a request
// with divisor==0 is answered directly from IDLE and the divider is not started.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. req_ready is the combinational grant, so it depends on req_valid.
// req_valid may drop without a transfer. resp_valid holds its response until
// the granted requester raises resp_ready.
module divider_rr_arbiter #(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
   input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
   output logic [NUM_REQ-1:0]       resp_valid,
   input  logic [NUM_REQ-1:0]       resp_ready,
   output logic [WIDTH-1:0]         resp_quotient,
   output logic [WIDTH-1:0]         resp_remainder,
   output logic                     resp_divide_by_zero,
   output logic                     div_go,
   output logic [WIDTH-1:0]         div_dividend,
   output logic [WIDTH-1:0]         div_divisor,
   input  logic                     div_done,
   input  logic [WIDTH-1:0]         div_quotient,
   input  logic [WIDTH-1:0]         div_remainder,
   input  logic                     div_divide_by_zero,
   output logic                     busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

   state_t             state;
   state_t             state_next;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   id;
   logic [IDX_W-1:0]   gnt_idx;
   logic [IDX_W-1:0]   cand_idx;
   logic [IDX_W:0]     cand_sum;
   logic               gnt_found;
   logic               accept;
   logic [WIDTH-1:0]   sel_dividend;
   logic [WIDTH-1:0]   sel_divisor;

   // Grant search: first valid requester after the last winner, with wrap.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand_sum  = '0;
      cand_idx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
            cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
         end
         cand_idx = cand_sum[IDX_W-1:0];
         if (!gnt_found && req_valid[cand_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand_idx;
         end
      end
      accept       = (state == IDLE) && gnt_found;
      sel_dividend = req_dividend[gnt_idx*WIDTH +: WIDTH];
      sel_divisor  = req_divisor[gnt_idx*WIDTH +: WIDTH];
   end

   // State register; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_next = state;
      req_ready  = '0;
      resp_valid = '0;
      div_go     = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (accept) begin
               req_ready[gnt_idx] = 1'b1;
`ifdef DIV_ARB_ZERO_BYPASS_EN
               state_next = (sel_divisor == '0) ? RESP : ISSUE;
`else
               state_next = ISSUE;
`endif
            end
         end
         ISSUE: begin
            div_go     = 1'b1;
            state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (div_done) begin
               state_next = RESP;
            end
         end
         RESP: begin
            resp_valid[id] = 1'b1;
            if (resp_ready[id]) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand, pointer and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr              <= IDX_W'(NUM_REQ-1);
         id                  <= '0;
         div_dividend        <= '0;
         div_divisor         <= '0;
         resp_quotient       <= '0;
         resp_remainder      <= '0;
         resp_divide_by_zero <= 1'b0;
      end else begin
         if (accept) begin
            rr_ptr       <= gnt_idx;
            id           <= gnt_idx;
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
`ifdef DIV_ARB_ZERO_BYPASS_EN
            if (sel_divisor == '0) begin
               resp_quotient       <= '1;
               resp_remainder      <= sel_dividend;
               resp_divide_by_zero <= 1'b1;
            end
`endif
         end
         if ((state == WAIT_DONE) && div_done) begin
            // On divide-by-zero the divider outputs are stale, so substitute.
            resp_divide_by_zero <= div_divide_by_zero;
            resp_quotient       <= div_divide_by_zero ? '1 : div_quotient;
            resp_remainder      <= div_divide_by_zero ? div_dividend : div_remainder;
         end
      end
   end

endmodule

// File: tb/tb_divider_rr_arbiter.sv
// Bench for divider_rr_arbiter (WIDTH=8, NUM_REQ=4) with a behavioural divider
// peer, a transaction-level model of the arbiter checked every cycle, and a
// scoreboard of hand-computed responses.
module tb_divider_rr_arbiter;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int EW = 2 + 1 + 2*W;
`ifdef DIV_ARB_ZERO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   req_valid    = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_dividend = '0;
   logic [N*W-1:0] req_divisor  = '0;
   logic [N-1:0]   resp_valid;
   logic [N-1:0]   resp_ready   = '1;
   logic [W-1:0]   resp_quotient, resp_remainder;
   logic           resp_divide_by_zero;
   logic           div_go;
   logic [W-1:0]   div_dividend, div_divisor;
   logic           div_done           = 1'b0;
   logic [W-1:0]   div_quotient       = '0;
   logic [W-1:0]   div_remainder      = '0;
   logic           div_divide_by_zero = 1'b0;
   logic           busy;

   divider_rr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
      .resp_divide_by_zero(resp_divide_by_zero),
      .div_go(div_go), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
      .div_divide_by_zero(div_divide_by_zero),
      .busy(busy)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- divider peer ----------------
   // Non-zero divisor: done WIDTH+1 cycles after go. Zero divisor: done one
   // cycle after go with deliberately stale quotient/remainder.
   logic         stray_done = 1'b0;
   int           dv_cnt = 0;
   logic [W-1:0] dv_a = '0, dv_b = '0;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_cnt   = 0;
         div_done = 1'b0;
      end else begin
         div_done = stray_done;
         if (dv_cnt > 0) begin
            dv_cnt--;
            if (dv_cnt == 0) begin
               div_done = 1'b1;
               if (dv_b == '0) begin
                  div_quotient       = 8'h5A;
                  div_remainder      = 8'hC3;
                  div_divide_by_zero = 1'b1;
               end else begin
                  div_quotient       = dv_a / dv_b;
                  div_remainder      = dv_a % dv_b;
                  div_divide_by_zero = 1'b0;
               end
            end
         end
         if (div_go) begin
            dv_a   = div_dividend;
            dv_b   = div_divisor;
            dv_cnt = (div_divisor == '0) ? 1 : W + 1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];

   // ---------------- arbiter model + compare ----------------
   bit           m_active = 1'b0;
   bit           m_bypass = 1'b0;
   bit           m_dbz    = 1'b0;
   int           m_id = 0, m_t = 0, m_resp_cyc = 0, m_ptr = N - 1;
   logic [W-1:0] m_q = '0, m_r = '0, m_la = '0, m_lb = '0;
   int           grant_log[$];

   function automatic int model_grant(input logic [N-1:0] v, input int ptr);
      int c;
      c = ptr;
      repeat (N) begin
         c = (c == N - 1) ? 0 : c + 1;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      int           g, rid;
      logic [N-1:0] exp_rr, exp_rv;
      logic [W-1:0] a, b;
      logic [EW-1:0] e;
      if (!rst_n) begin
         check("rst_req_ready", 32'(req_ready), 0);
         check("rst_resp_valid", 32'(resp_valid), 0);
         check("rst_busy", 32'(busy), 0);
         check("rst_div_go", 32'(div_go), 0);
         check("rst_quotient", 32'(resp_quotient), 0);
         check("rst_remainder", 32'(resp_remainder), 0);
         check("rst_dbz", 32'(resp_divide_by_zero), 0);
         check("rst_div_dividend", 32'(div_dividend), 0);
         check("rst_div_divisor", 32'(div_divisor), 0);
         m_active = 1'b0;
         m_ptr    = N - 1;
         m_la     = '0;
         m_lb     = '0;
      end else begin
         g      = -1;
         exp_rr = '0;
         if (!m_active) begin
            g = model_grant(req_valid, m_ptr);
            if (g >= 0) exp_rr[g] = 1'b1;
         end
         exp_rv = '0;
         if (m_active && cyc >= m_resp_cyc) exp_rv[m_id] = 1'b1;
         check("req_ready", 32'(req_ready), 32'(exp_rr));
         check("busy", 32'(busy), 32'(m_active));
         check("div_go", 32'(div_go), 32'(m_active && !m_bypass && cyc == m_t + 1));
         check("div_dividend", 32'(div_dividend), 32'(m_la));
         check("div_divisor", 32'(div_divisor), 32'(m_lb));
         check("resp_valid", 32'(resp_valid), 32'(exp_rv));
         if (exp_rv != '0) begin
            check("model_quotient", 32'(resp_quotient), 32'(m_q));
            check("model_remainder", 32'(resp_remainder), 32'(m_r));
            check("model_dbz", 32'(resp_divide_by_zero), 32'(m_dbz));
         end
         // Hand-computed expectations, popped on each response transfer.
         rid = -1;
         for (int k = 0; k < N; k++) if (resp_valid[k] && resp_ready[k]) rid = k;
         if (rid >= 0) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected: response to %0d with no expectation", rid);
            end else begin
               e = exp_q.pop_front();
               check("sb_id", 32'(rid), 32'(e[EW-1 -: 2]));
               check("sb_dbz", 32'(resp_divide_by_zero), 32'(e[2*W]));
               check("sb_quotient", 32'(resp_quotient), 32'(e[2*W-1 -: W]));
               check("sb_remainder", 32'(resp_remainder), 32'(e[W-1:0]));
            end
         end
         // Advance the model to what the next edge commits.
         if (g >= 0) begin
            a          = req_dividend[g*W +: W];
            b          = req_divisor[g*W +: W];
            m_active   = 1'b1;
            m_id       = g;
            m_t        = cyc;
            m_ptr      = g;
            m_la       = a;
            m_lb       = b;
            m_dbz      = (b == '0);
            m_q        = m_dbz ? '1 : a / b;
            m_r        = m_dbz ? a : a % b;
            m_bypass   = BYP && m_dbz;
            m_resp_cyc = cyc + (m_bypass ? 1 : (m_dbz ? 3 : 3 + W));
            grant_log.push_back(g);
         end else if (m_active && cyc >= m_resp_cyc && resp_ready[m_id]) begin
            m_active = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic lit_reset();
      check("lit_rst_req_ready", 32'(req_ready), 0);
      check("lit_rst_resp_valid", 32'(resp_valid), 0);
      check("lit_rst_busy", 32'(busy), 0);
      check("lit_rst_div_go", 32'(div_go), 0);
      check("lit_rst_quotient", 32'(resp_quotient), 0);
      check("lit_rst_remainder", 32'(resp_remainder), 0);
      check("lit_rst_div_dividend", 32'(div_dividend), 0);
   endtask

   task automatic drive_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
      req_valid[id]           = 1'b1;
      req_dividend[id*W +: W] = a;
      req_divisor[id*W +: W]  = b;
   endtask

   task automatic wait_accept(input int id, output int t);
      int n;
      bit got;
      got = 1'b0;
      n   = 0;
      t   = 0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         if (req_ready[id]) begin
            got = 1'b1;
            t   = cyc;
         end
      end
      check("accept_seen", 32'(got), 1);
   endtask

   task automatic wait_resp(input int id);
      int n;
      n = 0;
      while (!resp_valid[id] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("resp_seen", 32'(resp_valid[id]), 1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 0);
   endtask

   // One request with immediate response acceptance; checks go and latency.
   task automatic run_one(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                          input int exp_lat, input int exp_go);
      int t, n, go_cnt, go_cyc;
      bit got;
      exp_q.push_back({2'(id), edbz, eq, er});
      @(posedge clk); #1;
      drive_req(id, a, b);
      wait_accept(id, t);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      go_cnt = 0;
      go_cyc = -1;
      got    = 1'b0;
      n      = 0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         if (div_go) begin
            go_cnt++;
            if (go_cyc < 0) go_cyc = cyc;
         end
         if (resp_valid[id]) got = 1'b1;
      end
      check("resp_seen", 32'(got), 1);
      check("latency", 32'(cyc - t), 32'(exp_lat));
      check("go_count", 32'(go_cnt), 32'(exp_go));
      if (exp_go > 0) check("go_cycle", 32'(go_cyc - t), 1);
      wait_drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int t;
      #1;
      lit_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // All four requesters at once from reset: strict rotation 0,1,2,3,0.
      for (int i = 0; i < 5; i++) exp_q.push_back({2'(i % N), 1'b0, 8'd33, 8'd1});
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) drive_req(i, 8'd100, 8'd3);
      for (int n = 0; n < 300 && grant_log.size() < 5; n++) @(posedge clk);
      #1 req_valid = '0;
      wait_drain();
      check("grant_count", 32'(grant_log.size()), 5);
      if (grant_log.size() >= 5) begin
         check("grant0", 32'(grant_log[0]), 0);
         check("grant1", 32'(grant_log[1]), 1);
         check("grant2", 32'(grant_log[2]), 2);
         check("grant3", 32'(grant_log[3]), 3);
         check("grant4", 32'(grant_log[4]), 0);
      end

      // 200/7 from requester 2.
      run_one(2, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 11, 1);

      // 55/0 from requester 1.
      run_one(1, 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1, BYP ? 1 : 3, BYP ? 0 : 1);

      // 9/9 from requester 3 with its response held off for 20 cycles.
      resp_ready = 4'b0111;
      exp_q.push_back({2'd3, 1'b0, 8'd1, 8'd0});
      exp_q.push_back({2'd0, 1'b0, 8'd5, 8'd0});
      @(posedge clk); #1;
      drive_req(3, 8'd9, 8'd9);
      wait_accept(3, t);
      @(posedge clk); #1;
      req_valid[3] = 1'b0;
      wait_resp(3);
      @(posedge clk); #1;
      drive_req(0, 8'd10, 8'd2);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("hold_quotient", 32'(resp_quotient), 1);
         check("hold_remainder", 32'(resp_remainder), 0);
         check("hold_req_ready", 32'(req_ready), 0);
         check("hold_busy", 32'(busy), 1);
         check("hold_resp_valid", 32'(resp_valid), 32'h8);
      end
      @(posedge clk); #1;
      resp_ready = '1;
      @(negedge clk);
      @(negedge clk);
      check("release_idle_busy", 32'(busy), 0);
      check("release_grant0", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      wait_drain();

      // Stray done pulse while idle.
      @(posedge clk); #1;
      stray_done = 1'b1;
      @(posedge clk); #1;
      stray_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stray_resp_valid", 32'(resp_valid), 0);
         check("stray_busy", 32'(busy), 0);
      end

      // 255/1 aborted by reset three cycles after accept, then retried.
      @(posedge clk); #1;
      drive_req(0, 8'd255, 8'd1);
      wait_accept(0, t);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 lit_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run_one(0, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 11, 1);

      repeat (5) @(posedge clk);
      check("sb_leftover", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
